// File: rtl/medidor_pkg.sv
// Shared types and defaults for the wreal period/duty-cycle meter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package medidor_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ALTO = 2'd1,
    BAJO = 2'd2
  } estado_t;

  // Duty cycle as high time over period. A zero period yields 0.0 instead of a NaN.
  function automatic real calc_duty(input logic [31:0] alto, input logic [31:0] per);
    if (per == 32'd0) begin
      return 0.0;
    end
    return real'(alto) / real'(per);
  endfunction

endpackage

// File: rtl/detector_pulso.sv
// Thresholds a wreal input into a level bit each clock and flags its 0->1 transition.
// Latency: the pulse is high in the cycle after the first clock edge that samples the level above threshold.
// Backpressure: none; a level held for several clocks still produces one single-cycle pulse.
module detector_pulso #(
  parameter real UMBRAL = 0.5
) (
  input  logic clk,
  input  logic rst,
  input  real  nivel_i,
  output logic pulso_o
);

  logic nivel_q;
  logic previo_q;

  // Sample the thresholded level and keep the previous sample for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nivel_q  <= 1'b0;
      previo_q <= 1'b0;
    end else begin
      nivel_q  <= (nivel_i > UMBRAL);
      previo_q <= nivel_q;
    end
  end

  assign pulso_o = nivel_q & ~previo_q;

endmodule

// File: rtl/medidor_periodo_rnm.sv
// Measures the period and high time of a signal from its rising/falling pulses and derives the duty cycle.
// Latency: valido strobes one clock after the closing rising pulse is detected.
// Backpressure: none; results are overwritten by each new period, and the flags stay sticky until borrar.
module medidor_periodo_rnm
  import medidor_pkg::*;
#(
  parameter int  CNT_W  = CNT_W_DEF,
  parameter real UMBRAL = 0.5
) (
  input  logic             clk,
  input  logic             rst,
  input  real              rising_edge,
  input  real              falling_edge,
  input  logic             borrar,
  output logic [CNT_W-1:0] periodo,
  output logic [CNT_W-1:0] t_alto,
  output logic             valido,
  output real              ciclo_trabajo,
  output logic             desborde,
  output logic             error_glitch
);

  estado_t          estado_q, estado_d;
  logic             rise_pls, fall_pls;
  logic             glitch, sube, baja, cnt_max;
  logic             carga_uno, incr, limpia, fija_alto, cierra, ovf;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] t_alto_int_q, periodo_q, t_alto_q;
  logic             valido_q;
  logic             desborde_q, desborde_d;
  logic             glitch_q, glitch_d;
  real              ciclo_q;

  detector_pulso #(.UMBRAL(UMBRAL)) u_det_sube (
    .clk    (clk),
    .rst    (rst),
    .nivel_i(rising_edge),
    .pulso_o(rise_pls)
  );

  detector_pulso #(.UMBRAL(UMBRAL)) u_det_baja (
    .clk    (clk),
    .rst    (rst),
    .nivel_i(falling_edge),
    .pulso_o(fall_pls)
  );

  // Coincident pulses are ambiguous: they are flagged and hidden from the FSM.
  assign glitch  = rise_pls & fall_pls;
  assign sube    = rise_pls & ~fall_pls;
  assign baja    = fall_pls & ~rise_pls;
  assign cnt_max = &cnt_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= IDLE;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state logic; an edge always takes precedence over the timeout.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      IDLE: if (sube) estado_d = ALTO;
      ALTO: begin
        if (sube)         estado_d = ALTO;
        else if (baja)    estado_d = BAJO;
        else if (cnt_max) estado_d = IDLE;
      end
      BAJO: begin
        if (sube)         estado_d = ALTO;
        else if (cnt_max) estado_d = IDLE;
      end
      default: estado_d = IDLE;
    endcase
  end

  // Per-state datapath actions. A rising pulse in ALTO means a falling edge was missed, so the count restarts.
  always_comb begin
    carga_uno = 1'b0;
    incr      = 1'b0;
    limpia    = 1'b0;
    fija_alto = 1'b0;
    cierra    = 1'b0;
    ovf       = 1'b0;
    case (estado_q)
      IDLE: carga_uno = sube;
      ALTO: begin
        if (sube) begin
          carga_uno = 1'b1;
        end else if (baja) begin
          fija_alto = 1'b1;
          incr      = 1'b1;
        end else if (cnt_max) begin
          ovf    = 1'b1;
          limpia = 1'b1;
        end else begin
          incr = 1'b1;
        end
      end
      BAJO: begin
        if (sube) begin
          cierra    = 1'b1;
          carga_uno = 1'b1;
        end else if (cnt_max) begin
          ovf    = 1'b1;
          limpia = 1'b1;
        end else begin
          incr = 1'b1;
        end
      end
      default: limpia = 1'b1;
    endcase
  end

  // Counter next value and sticky flags; a new set condition beats borrar.
  always_comb begin
    cnt_d = cnt_q;
    if (carga_uno)   cnt_d = CNT_W'(1);
    else if (limpia) cnt_d = '0;
    else if (incr)   cnt_d = cnt_q + CNT_W'(1);
    desborde_d = ovf    ? 1'b1 : (borrar ? 1'b0 : desborde_q);
    glitch_d   = glitch ? 1'b1 : (borrar ? 1'b0 : glitch_q);
  end

  // Datapath registers: counter, latched high time, published results and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      t_alto_int_q <= '0;
      periodo_q    <= '0;
      t_alto_q     <= '0;
      valido_q     <= 1'b0;
      ciclo_q      <= 0.0;
      desborde_q   <= 1'b0;
      glitch_q     <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (fija_alto) t_alto_int_q <= cnt_q;
      if (cierra) begin
        periodo_q <= cnt_q;
        t_alto_q  <= t_alto_int_q;
        ciclo_q   <= calc_duty(32'(t_alto_int_q), 32'(cnt_q));
      end
      valido_q   <= cierra;
      desborde_q <= desborde_d;
      glitch_q   <= glitch_d;
    end
  end

  assign periodo       = periodo_q;
  assign t_alto        = t_alto_q;
  assign valido        = valido_q;
  assign ciclo_trabajo = ciclo_q;
  assign desborde      = desborde_q;
  assign error_glitch  = glitch_q;

endmodule

// File: tb/tb_medidor_periodo_rnm.sv
// Scoreboard bench for medidor_periodo_rnm: directed pulse trains with hand-computed periods.
// Expected results are queued at stimulus time and popped by a monitor on each valido strobe.
// Flags and reset values are checked directly at fixed cycle points.
module tb_medidor_periodo_rnm;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  real          re_in;
  real          fe_in;
  logic         borrar;
  logic [W-1:0] periodo;
  logic [W-1:0] t_alto;
  logic         valido;
  real          ciclo_trabajo;
  logic         desborde;
  logic         error_glitch;

  int  n_chk  = 0;
  int  n_pass = 0;
  int  n_exp  = 0;
  int  n_seen = 0;
  int  exp_per[$];
  int  exp_hi[$];
  real exp_duty[$];

  medidor_periodo_rnm #(.CNT_W(W), .UMBRAL(0.5)) dut (
    .clk          (clk),
    .rst          (rst),
    .rising_edge  (re_in),
    .falling_edge (fe_in),
    .borrar       (borrar),
    .periodo      (periodo),
    .t_alto       (t_alto),
    .valido       (valido),
    .ciclo_trabajo(ciclo_trabajo),
    .desborde     (desborde),
    .error_glitch (error_glitch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
  endtask

  task automatic chk_r(input string nm, input real act, input real req);
    real d;
    n_chk++;
    d = act - req;
    if (d < 0.0) d = -d;
    if (d < 1.0e-9) n_pass++;
    else $display("FAIL %s: got %f, expected %f", nm, act, req);
  endtask

  task automatic wait_c(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_r();
    re_in = 1.0;
    @(negedge clk);
    re_in = 0.0;
  endtask

  task automatic pulse_f();
    fe_in = 1.0;
    @(negedge clk);
    fe_in = 0.0;
  endtask

  task automatic expect_res(input int per, input int hi, input real duty);
    exp_per.push_back(per);
    exp_hi.push_back(hi);
    exp_duty.push_back(duty);
    n_exp++;
  endtask

  // Monitor: every valido strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (valido) begin
      n_seen++;
      if (exp_per.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_valido: got valido=1 with periodo=%0d, expected no strobe", periodo);
      end else begin
        chk("periodo", 32'(periodo), exp_per.pop_front());
        chk("t_alto", 32'(t_alto), exp_hi.pop_front());
        chk_r("ciclo_trabajo", ciclo_trabajo, exp_duty.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    re_in  = 0.0;
    fe_in  = 0.0;
    borrar = 1'b0;
    wait_c(2);
    chk("rst_periodo", 32'(periodo), 0);
    chk("rst_t_alto", 32'(t_alto), 0);
    chk("rst_valido", 32'(valido), 0);
    chk_r("rst_ciclo", ciclo_trabajo, 0.0);
    chk("rst_desborde", 32'(desborde), 0);
    chk("rst_glitch", 32'(error_glitch), 0);
    rst = 1'b0;
    wait_c(2);

    // Square wave toggling every 10 cycles: 20/10, twice.
    pulse_r(); wait_c(9); pulse_f(); wait_c(9);
    expect_res(20, 10, 0.5);
    pulse_r(); wait_c(9); pulse_f(); wait_c(9);
    expect_res(20, 10, 0.5);
    pulse_r();

    // High 5, low 15.
    wait_c(4); pulse_f(); wait_c(14);
    expect_res(20, 5, 0.25);
    pulse_r();

    // High 3, low 7; the closing rising pulse is held 3 cycles and counts once.
    wait_c(2); pulse_f(); wait_c(6);
    expect_res(10, 3, 0.3);
    re_in = 1.0; wait_c(3); re_in = 0.0;

    // Missed falling edge: a second rise 5 cycles in restarts the measurement.
    wait_c(2); pulse_r();
    wait_c(6); pulse_f(); wait_c(12);
    expect_res(20, 7, 0.35);
    pulse_r();

    // Coincident pulses at 0.8 with borrar in the same cycle: flag set wins, FSM ignores them.
    wait_c(3);
    re_in = 0.8; fe_in = 0.8;
    @(negedge clk);
    re_in = 0.0; fe_in = 0.0; borrar = 1'b1;
    @(negedge clk);
    borrar = 1'b0;
    chk("glitch_set_wins", 32'(error_glitch), 1);
    wait_c(2); pulse_f(); wait_c(7);
    expect_res(16, 8, 0.5);
    pulse_r();
    borrar = 1'b1;
    @(negedge clk);
    borrar = 1'b0;
    chk("glitch_cleared", 32'(error_glitch), 0);

    // Reset 3 cycles after a falling pulse aborts the measurement.
    wait_c(8); pulse_f(); wait_c(2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_periodo", 32'(periodo), 0);
    chk("rst2_t_alto", 32'(t_alto), 0);
    chk_r("rst2_ciclo", ciclo_trabajo, 0.0);
    chk("rst2_valido", 32'(valido), 0);
    rst = 1'b0;
    wait_c(2);

    // Inputs held at 0.4, below threshold: nothing is detected.
    re_in = 0.4; fe_in = 0.4;
    wait_c(40);
    chk("sub_umbral_periodo", 32'(periodo), 0);
    re_in = 0.0; fe_in = 0.0;
    wait_c(2);

    // Fresh measurement after reset: valido only on the second rise.
    pulse_r(); wait_c(5); pulse_f(); wait_c(17);
    expect_res(24, 6, 0.25);
    pulse_r();

    // Silence after the rise: counter times out 255 cycles after loading 1.
    wait_c(255);
    chk("desborde_before", 32'(desborde), 0);
    wait_c(1);
    chk("desborde_set", 32'(desborde), 1);
    chk("ovf_periodo_kept", 32'(periodo), 24);
    chk("ovf_t_alto_kept", 32'(t_alto), 6);
    borrar = 1'b1;
    @(negedge clk);
    borrar = 1'b0;
    chk("desborde_cleared", 32'(desborde), 0);

    // Back in IDLE: a stray falling pulse is ignored, then a clean period is measured.
    pulse_f(); wait_c(3);
    pulse_r(); wait_c(4); pulse_f(); wait_c(9);
    expect_res(15, 5, 1.0 / 3.0);
    pulse_r();
    wait_c(6);

    chk("pendientes", exp_per.size(), 0);
    chk("num_valido", n_seen, n_exp);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
